// File: rtl/r22_sdf_stage_ctrl.sv
// Sequencing controller for one radix-2^2 SDF stage pair (BF2I -> BF2II -> twiddle).
// Decodes are combinational from the registered counters and the sample presented this cycle.
module r22_sdf_stage_ctrl #(
   parameter int LOG2N = 6,
   parameter int STAGE = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   input  logic             i_sync,
   input  logic             i_flush,
   output logic             o_bf1_ctrl,
   output logic             o_bf2_ctrl,
   output logic             o_bf2_conj,
   output logic [LOG2N-1:0] o_tw_addr,
   output logic             o_out_valid,
   output logic             o_frame_done
);

   localparam int B1 = LOG2N - 2 * STAGE - 1;
   localparam int B2 = B1 - 1;
   localparam int FW = B1 + 1;

   localparam logic [1:0] FILL1 = 2'd0;
   localparam logic [1:0] FILL2 = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;

   localparam logic [FW-1:0]    L1_LAST   = FW'((1 << B1) - 1);
   localparam logic [FW-1:0]    L2_LAST   = FW'((1 << B2) - 1);
   localparam logic [FW-1:0]    FILL_ZERO = {FW{1'b0}};
   localparam logic [FW-1:0]    FILL_ONE  = FW'(1);
   localparam logic [LOG2N-1:0] CNT_ZERO  = {LOG2N{1'b0}};
   localparam logic [LOG2N-1:0] CNT_ONE   = LOG2N'(1);
   localparam logic [LOG2N-1:0] CNT_LAST  = {LOG2N{1'b1}};
   localparam logic [LOG2N-1:0] M_MASK    = LOG2N'((1 << B2) - 1);

   logic [LOG2N-1:0] cnt1_r, cnt2_r, cnt3_r;
   logic [FW-1:0]    fill_r;
   logic [1:0]       state_r;
   logic             tail_r;
   logic             done_r;

   logic             adv_s, restart_s, run_s, fill1_s;
   logic [LOG2N-1:0] cnt1_s, cnt2_s, cnt3_s;
   logic [LOG2N-1:0] cnt1_nx_s, cnt2_nx_s, cnt3_nx_s;
   logic [FW-1:0]    fill_s, fill_nx_s;
   logic [1:0]       state_s, state_nx_s;
   logic [LOG2N-1:0] m_s;
   logic [1:0]       q_s;
   logic [LOG2N+1:0] prod_s;

   // Effective state for the sample being presented; a sync sample is index 0 of a fresh fill.
   always_comb begin
      adv_s     = i_valid | i_flush;
      restart_s = i_valid & i_sync;
      if (restart_s) begin
         state_s = FILL1;
         fill_s  = FILL_ZERO;
         cnt1_s  = CNT_ZERO;
         cnt2_s  = CNT_ZERO;
         cnt3_s  = CNT_ZERO;
      end else begin
         state_s = state_r;
         fill_s  = fill_r;
         cnt1_s  = cnt1_r;
         cnt2_s  = cnt2_r;
         cnt3_s  = cnt3_r;
      end
      run_s   = (state_s == RUN);
      fill1_s = (state_s == FILL1);
   end

   // Next counter and fill-state values, committed only on an advance.
   always_comb begin
      cnt1_nx_s = cnt1_s + CNT_ONE;
      if (fill1_s) begin
         cnt2_nx_s = CNT_ZERO;
      end else begin
         cnt2_nx_s = cnt2_s + CNT_ONE;
      end
      if (run_s) begin
         cnt3_nx_s = cnt3_s + CNT_ONE;
      end else begin
         cnt3_nx_s = CNT_ZERO;
      end
      state_nx_s = state_s;
      fill_nx_s  = fill_s;
      case (state_s)
         FILL1: begin
            if (fill_s == L1_LAST) begin
               state_nx_s = FILL2;
               fill_nx_s  = FILL_ZERO;
            end else begin
               fill_nx_s = fill_s + FILL_ONE;
            end
         end
         FILL2: begin
            if (fill_s == L2_LAST) begin
               state_nx_s = RUN;
               fill_nx_s  = FILL_ZERO;
            end else begin
               fill_nx_s = fill_s + FILL_ONE;
            end
         end
         RUN: begin
            state_nx_s = RUN;
            fill_nx_s  = fill_s;
         end
         default: begin
            state_nx_s = FILL1;
            fill_nx_s  = FILL_ZERO;
         end
      endcase
   end

   // Quarter order 0,2,1,3 falls out of reading {cnt3[b2], cnt3[b1]} as a 2-bit number.
   always_comb begin
      m_s    = cnt3_s & M_MASK;
      q_s    = {cnt3_s[B2], cnt3_s[B1]};
      prod_s = {2'b00, m_s} * {{LOG2N{1'b0}}, q_s};
      o_bf1_ctrl = cnt1_s[B1];
      if (fill1_s) begin
         o_bf2_ctrl = 1'b0;
         o_bf2_conj = 1'b0;
      end else begin
         o_bf2_ctrl = cnt2_s[B2];
         o_bf2_conj = cnt2_s[B1] & cnt2_s[B2];
      end
      if (run_s) begin
         o_tw_addr = LOG2N'(prod_s << (2 * STAGE));
      end else begin
         o_tw_addr = CNT_ZERO;
      end
      o_out_valid = adv_s & run_s & ~(tail_r & ~i_valid);
   end

   // Sequencing state, flush-tail flag and the frame-done pulse.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt1_r  <= CNT_ZERO;
         cnt2_r  <= CNT_ZERO;
         cnt3_r  <= CNT_ZERO;
         fill_r  <= FILL_ZERO;
         state_r <= FILL1;
         tail_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         if (adv_s) begin
            cnt1_r  <= cnt1_nx_s;
            cnt2_r  <= cnt2_nx_s;
            cnt3_r  <= cnt3_nx_s;
            fill_r  <= fill_nx_s;
            state_r <= state_nx_s;
            if (i_valid) begin
               tail_r <= 1'b0;
            end else if (run_s) begin
               tail_r <= 1'b1;
            end else begin
               tail_r <= tail_r;
            end
         end
         done_r <= adv_s & run_s & (cnt3_s == CNT_LAST);
      end
   end

   assign o_frame_done = done_r;

endmodule

// File: tb/tb_r22_sdf_stage_ctrl.sv
// Directed bench for r22_sdf_stage_ctrl: a k=0 and a k=2 instance (LOG2N=6) share stimulus.
module tb_r22_sdf_stage_ctrl;

   logic clk = 1'b0;
   logic rst, valid, sync, flush;
   logic       a_bf1, a_bf2, a_conj, a_ov, a_done;
   logic [5:0] a_tw;
   logic       b_bf1, b_bf2, b_conj, b_ov, b_done;
   logic [5:0] b_tw;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       v;
      logic       bf1, bf2, conj;
      logic [5:0] tw;
      logic       ov, done;
   } vec_t;

   vec_t tab[$];

   always #5 clk = ~clk;

   r22_sdf_stage_ctrl #(.LOG2N(6), .STAGE(0)) u_k0 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sync(sync), .i_flush(flush),
      .o_bf1_ctrl(a_bf1), .o_bf2_ctrl(a_bf2), .o_bf2_conj(a_conj),
      .o_tw_addr(a_tw), .o_out_valid(a_ov), .o_frame_done(a_done));

   r22_sdf_stage_ctrl #(.LOG2N(6), .STAGE(2)) u_k2 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_sync(sync), .i_flush(flush),
      .o_bf1_ctrl(b_bf1), .o_bf2_ctrl(b_bf2), .o_bf2_conj(b_conj),
      .o_tw_addr(b_tw), .o_out_valid(b_ov), .o_frame_done(b_done));

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%0d want=%0d", nm, idx, act, exp);
      end
   endtask

   // One clock: drive just after the rising edge, return at the falling edge for sampling.
   task automatic cyc(input logic v, input logic s, input logic f);
      @(posedge clk);
      #1;
      valid = v;
      sync  = s;
      flush = f;
      @(negedge clk);
   endtask

   // Expected k=0 decodes for sample index n since reset/sync (fill 32 + 16, quarters 0,2,1,3).
   function automatic vec_t mk0(int n, logic v, logic dn);
      vec_t e;
      int   c2, c3, q;
      e.v    = v;
      e.bf1  = ((n % 64) >= 32);
      e.bf2  = 1'b0;
      e.conj = 1'b0;
      e.tw   = 6'd0;
      e.ov   = 1'b0;
      e.done = dn;
      if (n >= 32) begin
         c2     = (n - 32) % 64;
         e.bf2  = (((c2 / 16) % 2) == 1);
         e.conj = (c2 >= 48);
      end
      if (n >= 48) begin
         c3 = (n - 48) % 64;
         case (c3 / 16)
            0:       q = 0;
            1:       q = 2;
            2:       q = 1;
            default: q = 3;
         endcase
         e.tw = 6'(((c3 % 16) * q) % 64);
         e.ov = v;
      end
      return e;
   endfunction

   function automatic int gaps_before(int n);
      case (n)
         20:      return 3;
         112:     return 1;
         130:     return 7;
         150:     return 2;
         default: return 0;
      endcase
   endfunction

   initial begin
      int   n;
      logic prev_end;
      vec_t e;

      // Stimulus table for the k=0 instance: 180 samples with gaps, expected from mk0.
      prev_end = 1'b0;
      for (int i = 0; i < 180; i++) begin
         for (int g = 0; g < gaps_before(i); g++) begin
            tab.push_back(mk0(i, 1'b0, prev_end));
            prev_end = 1'b0;
         end
         tab.push_back(mk0(i, 1'b1, prev_end));
         prev_end = (i >= 48) && (((i - 48) % 64) == 63);
      end

      rst = 1'b1; valid = 1'b0; sync = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_bf1", 0, a_bf1, 1'b0);
      chk("rst_bf2", 0, a_bf2, 1'b0);
      chk("rst_conj", 0, a_conj, 1'b0);
      chk("rst_tw", 0, a_tw, 6'd0);
      chk("rst_ov", 0, a_ov, 1'b0);
      chk("rst_done", 0, a_done, 1'b0);

      foreach (tab[i]) begin
         cyc(tab[i].v, 1'b0, 1'b0);
         chk("tab_bf1", i, a_bf1, tab[i].bf1);
         chk("tab_bf2", i, a_bf2, tab[i].bf2);
         chk("tab_conj", i, a_conj, tab[i].conj);
         chk("tab_tw", i, a_tw, tab[i].tw);
         chk("tab_ov", i, a_ov, tab[i].ov);
         chk("tab_done", i, a_done, tab[i].done);
      end

      // Flush: valid+flush is real, a flush-only tail is not, valid clears the tail.
      n = 180;
      cyc(1'b1, 1'b0, 1'b1);
      chk("vf_ov", n, a_ov, 1'b1);
      e = mk0(n, 1'b1, 1'b0);
      chk("vf_tw", n, a_tw, e.tw);
      n++;
      cyc(1'b0, 1'b0, 1'b1);
      e = mk0(n, 1'b1, 1'b0);
      chk("fl1_tw", n, a_tw, e.tw);
      n++;
      cyc(1'b0, 1'b0, 1'b1);
      e = mk0(n, 1'b1, 1'b0);
      chk("fl2_ov", n, a_ov, 1'b0);
      chk("fl2_bf1", n, a_bf1, e.bf1);
      chk("fl2_tw", n, a_tw, e.tw);
      n++;
      cyc(1'b1, 1'b0, 1'b0);
      chk("postfl_ov", n, a_ov, 1'b1);
      n++;

      // Hard restart at cnt1 = 20 in RUN (cnt2 = 52, cnt3 = 36 would give 1,1,4).
      while ((n % 64) != 20) begin
         cyc(1'b1, 1'b0, 1'b0);
         e = mk0(n, 1'b1, 1'b0);
         chk("pre_sync_bf2", n, a_bf2, e.bf2);
         n++;
      end
      cyc(1'b1, 1'b1, 1'b0);
      chk("sync_bf1", 0, a_bf1, 1'b0);
      chk("sync_bf2", 0, a_bf2, 1'b0);
      chk("sync_conj", 0, a_conj, 1'b0);
      chk("sync_tw", 0, a_tw, 6'd0);
      chk("sync_ov", 0, a_ov, 1'b0);
      for (int m = 1; m <= 85; m++) begin
         cyc(1'b1, 1'b0, 1'b0);
         chk("resync_ov", m, a_ov, (m >= 48) ? 1'b1 : 1'b0);
         if (m == 32) chk("resync_bf1", m, a_bf1, 1'b1);
         if (m == 47) chk("resync_tw47", m, a_tw, 6'd0);
         if (m == 48) chk("resync_bf2", m, a_bf2, 1'b1);
         if (m == 69) chk("tw_cnt3_21", m, a_tw, 6'd10);
         if (m == 85) chk("tw_cnt3_37", m, a_tw, 6'd5);
      end

      // k=2 instance: L1=2, L2=1, RUN from sample 3, twiddle always 0.
      cyc(1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("k2_rst_ov", 0, b_ov, 1'b0);
      chk("k2_rst_bf1", 0, b_bf1, 1'b0);
      for (int k = 0; k <= 66; k++) begin
         cyc(1'b1, 1'b0, 1'b0);
         chk("k2_bf1", k, b_bf1, (((k % 64) / 2) % 2 == 1) ? 1'b1 : 1'b0);
         chk("k2_bf2", k, b_bf2, (k >= 2 && ((k - 2) % 2) == 1) ? 1'b1 : 1'b0);
         chk("k2_conj", k, b_conj, (k >= 2 && ((k - 2) % 4) == 3) ? 1'b1 : 1'b0);
         chk("k2_tw", k, b_tw, 6'd0);
         chk("k2_ov", k, b_ov, (k >= 3) ? 1'b1 : 1'b0);
         chk("k2_done", k, b_done, 1'b0);
      end
      // Sample 66 carries cnt3 = 63; reset mid-cycle must clear outputs and suppress the pulse.
      #1 rst = 1'b1;
      #1;
      chk("arst_bf1", 0, b_bf1, 1'b0);
      chk("arst_bf2", 0, b_bf2, 1'b0);
      chk("arst_conj", 0, b_conj, 1'b0);
      chk("arst_tw", 0, b_tw, 6'd0);
      chk("arst_ov", 0, b_ov, 1'b0);
      chk("arst_done", 0, b_done, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      valid = 1'b0;
      @(negedge clk);
      chk("arst_done_after", 1, b_done, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("arst_done_after", 2, b_done, 1'b0);
      chk("arst_bf2_after", 2, b_bf2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
